// File: rtl/tff_period_meter_if.sv
// Bundles the monitored T flip-flop signals and the meter's status outputs.
//   enable       : enable shared with the T flip-flop (1 = toggling expected)
//   q            : T flip-flop output, synchronous to the shared clock
//   period       : last measured rising-to-rising period, in cycles
//   period_valid : one-cycle pulse when period is updated
//   edge_count   : saturating count of rising edges of q seen while not IDLE
//   stall        : high while q has stopped toggling under enable
//   state        : meter state, IDLE=0 ARMED=1 MEASURE=2 STALL=3
// master = the side driving enable/q (flip-flop stage or bench),
// slave  = the meter itself.
interface tff_period_meter_if #(
  parameter int CNT_W = 8
);
  logic             enable;
  logic             q;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic [CNT_W-1:0] edge_count;
  logic             stall;
  logic [1:0]       state;

  modport master (
    output enable, q,
    input  period, period_valid, edge_count, stall, state
  );

  modport slave (
    input  enable, q,
    output period, period_valid, edge_count, stall, state
  );
endinterface

// File: rtl/tff_period_meter.sv
// Period meter for a T flip-flop output. Measures the number of clock
// cycles between consecutive rising edges of q, counts rising edges
// (saturating) and flags a stall when q stops rising for TIMEOUT cycles
// while enabled. All outputs are registered; state changes take effect on
// the same edge that samples their cause.
// Ports:
//   clk   : sole clock, rising edge
//   reset : synchronous active-low reset
//   bus   : tff_period_meter_if slave (enable/q in, status out)
// Parameters:
//   CNT_W   : width of the cycle counter, period and edge_count
//   TIMEOUT : cycles without a rise (while enabled) before stall,
//             2 <= TIMEOUT <= 2**CNT_W-1
module tff_period_meter #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  tff_period_meter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2,
    STALL   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  state_t           state_q;
  logic             q_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period_q;
  logic             pv_q;
  logic [CNT_W-1:0] edges_q;
  logic             stall_q;
  logic             rise;

  assign rise = bus.q & ~q_d;

  // cnt holds the number of edges since the reference point (ARMED entry
  // or last rise), so at the next rise it equals the period directly.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      q_d      <= 1'b0;
      cnt      <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      edges_q  <= '0;
      stall_q  <= 1'b0;
    end else begin
      q_d  <= bus.q;
      pv_q <= 1'b0;
      if (!bus.enable) begin
        state_q <= IDLE;
        cnt     <= '0;
        stall_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            // a rise coinciding with the enable edge is deliberately ignored
            state_q <= ARMED;
            cnt     <= CNT_ONE;
          end
          ARMED: begin
            if (rise) begin
              state_q <= MEASURE;
              cnt     <= CNT_ONE;
              edges_q <= sat_inc(edges_q);
            end else if (cnt == CNT_TMO) begin
              state_q <= STALL;
              stall_q <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          MEASURE: begin
            // rise wins over timeout, so a period of exactly TIMEOUT is valid
            if (rise) begin
              period_q <= cnt;
              pv_q     <= 1'b1;
              cnt      <= CNT_ONE;
              edges_q  <= sat_inc(edges_q);
            end else if (cnt == CNT_TMO) begin
              state_q <= STALL;
              stall_q <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          STALL: begin
            // the interval spanning a stall is never reported as a period
            if (rise) begin
              state_q <= MEASURE;
              cnt     <= CNT_ONE;
              edges_q <= sat_inc(edges_q);
              stall_q <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt     <= '0;
            stall_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.period       = period_q;
  assign bus.period_valid = pv_q;
  assign bus.edge_count   = edges_q;
  assign bus.stall        = stall_q;
  assign bus.state        = state_q;

endmodule

// File: doc/tff_period_meter.md
# tff_period_meter

Downstream monitor for the T flip-flop stage. It samples the flip-flop's `q` output and the same `enable` that drives the flip-flop, and measures the clock-cycle period between consecutive rising edges of `q`. It also counts rising edges and flags a stall when `q` stops toggling while enabled. It sits directly after the toggle flip-flop, on its clock, and feeds status/debug logic.

## Interface
- `CNT_W`, 8, width of the cycle counter, `period` and `edge_count`.
- `TIMEOUT`, 16, cycles without a rising edge of `q` (while enabled) before `stall`. Legal range: 2 ≤ TIMEOUT ≤ 2^CNT_W − 1.

- `clk`  in  1  sole clock, rising-edge.
- `reset`  in  1  synchronous, active-low reset, sampled on `clk` rising edge.
- `enable`  in  1  same enable that drives the T flip-flop; 1 = toggling expected.
- `q`  in  1  T flip-flop output, synchronous to `clk`.
- `period`  out  CNT_W  last measured rising-to-rising period, in cycles.
- `period_valid`  out  1  one-cycle pulse; `period` updated this cycle.
- `edge_count`  out  CNT_W  rising edges of `q` seen while not IDLE; saturating.
- `stall`  out  1  high while in STALL.
- `state`  out  2  FSM state: IDLE=0, ARMED=1, MEASURE=2, STALL=3.

## Operation
- `q_d` register holds the previous `q` and updates every cycle in every state. Reset value is 0.
- `rise = q & ~q_d`.
- Internal `cnt` (CNT_W bits) never exceeds TIMEOUT.
- Priority on each edge: reset low > `enable`=0 > rise > timeout (`cnt == TIMEOUT`) > hold/increment.
- IDLE:
  - `cnt`=0, `stall`=0.
  - `enable`=1 → ARMED with `cnt`=1.
  - A rise in the same cycle is ignored; it is not counted.
- ARMED (waiting for the first edge):
  - rise → MEASURE, `cnt`=1, `edge_count`+1, no `period_valid`.
  - `cnt==TIMEOUT` → STALL.
  - Otherwise `cnt`+1.
- MEASURE:
  - rise → `period`=`cnt`, `period_valid`=1, `cnt`=1, `edge_count`+1, stay in MEASURE.
  - `cnt==TIMEOUT` without a rise → STALL. `period` is unchanged.
  - Otherwise `cnt`+1.
- STALL:
  - `stall`=1.
  - rise → MEASURE, `cnt`=1, `edge_count`+1, `stall`=0, no `period_valid`. The interval across a stall is never reported.
- `enable`=0 in any non-IDLE state → IDLE. `period` and `edge_count` hold. No `period_valid`.
- `edge_count` saturates at 2^CNT_W − 1. It is cleared only by reset.
- `period` holds until the next valid measurement or reset.

## Timing
- Reset low at a clock edge: after that edge, `state`=IDLE and `period`, `period_valid`, `edge_count`, `stall`, `cnt`, `q_d` are all 0. This holds from any state, including mid-measurement.
- All outputs are registered. Nothing is combinational from inputs.
- A rise sampled at edge k produces `period_valid`/`period`/`edge_count` updates visible after edge k.
- `period_valid` is never high two consecutive cycles.
- Period semantics: rises sampled at edges k and k+N give `period`=N.
  - Minimum is 2, when `q` toggles every cycle.
  - Maximum is TIMEOUT: a rise at the same edge where `cnt==TIMEOUT` wins over the timeout.
- Stall latency: TIMEOUT cycles after entering ARMED, or after the last rise in MEASURE, `stall` goes high.
- State transitions take effect on the same edge as the causing sample. There is no extra pipeline stage.

## Test plan
- Reset low 2 cycles, inputs random → all outputs 0, `state`=0. Release with `enable`=0 → outputs stay 0.
- `enable`=1, `q` toggling every cycle → first rise: `state`=2, `edge_count`=1, no pulse. Then `period_valid` pulses every 2 cycles with `period`=2, and `edge_count` increments by 1 each rise.
- `q` high 3 / low 3 cycles → `period`=6 on every pulse after the first rise. Then switch to high 8 / low 8 with TIMEOUT=16 → `period`=16, no stall.
- `enable`=1, `q` held 0, TIMEOUT=16 → `stall`=1 and `state`=3 exactly 16 cycles after entering ARMED. Next rise → `stall`=0, `state`=2, no pulse. Following rise 4 cycles later → `period`=4.
- `enable` dropped mid-MEASURE with `period`=2 latched → `state`=0 after that edge, `period` stays 2, no `period_valid`. A rise on the same edge as the `enable` drop is not counted.
- CNT_W=4, TIMEOUT=15, 20 rises → `edge_count`=15 (saturated). Reset low mid-MEASURE → all outputs 0 after the edge.
